audio_clk_gen: RTL and testbench

// - Parametrised audio clock generator: phase-accumulator (NCO) MCLK, integer-divided BCLK, LRCK frame clock.
// - Emits single-cycle strobes (mclk_tick, bclk_rise, bclk_fall, frame_start) for the I2S serializer/deserializer.
// - Runtime-retunable increment via valid/ready handshake; new rate takes effect only at a frame boundary (no glitches).

---
 rtl/audio_clk_gen.sv | 204 ++++++++++++++++++++
 tb/tb_audio_clk_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_clk_gen.sv
// -----------------------------------------------------------------------------
// audio_clk_gen
//
// Audio clock generator for the I2S serializer/deserializer.
//   - A phase accumulator (NCO) produces MCLK. Each accumulator wrap is one
//     mclk_tick.
//   - BCLK is MCLK divided by the integer BCLK_DIV, counted in mclk_ticks.
//   - LRCK toggles every SLOT_BITS BCLK periods.
//   - The increment can be changed at runtime through a valid/ready
//     handshake. A new increment is held pending and only takes effect at a
//     frame boundary, or on the next clock while stopped. This keeps the
//     generated clocks free of glitches.
//
// Optional feature: define ACG_FRAME_CNT_EN to add the frame_cnt output
// together with its counter.
//
// Parameters:
//   ACC_W      phase accumulator width
//   DEF_INC    increment loaded at reset
//   BCLK_DIV   mclk_ticks per BCLK period (even, >= 2)
//   SLOT_BITS  BCLK periods per LRCK half-frame
//   FCNT_W     frame counter width (ACG_FRAME_CNT_EN only)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   run          1 = generate clocks; 0 = hold counters and outputs at zero
//   cfg_valid    a new increment is offered
//   cfg_inc      new increment value (0 stalls the accumulator)
//   cfg_ready    1 = no config pending; an offered increment will be accepted
//   mclk         MSB of the phase accumulator
//   mclk_tick    1-clk pulse in the cycle the accumulator holds its wrapped value
//   bclk         bit clock
//   bclk_rise    1-clk pulse in the cycle bclk goes 0->1
//   bclk_fall    1-clk pulse in the cycle bclk goes 1->0
//   lrck         0 = left channel, 1 = right channel
//   frame_start  1-clk pulse in the cycle lrck goes 1->0
//   frame_cnt    frames elapsed, wrapping (ACG_FRAME_CNT_EN only)
// -----------------------------------------------------------------------------
module audio_clk_gen #(
  parameter int ACC_W     = 18,
  parameter int DEF_INC   = 63,
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32,
  parameter int FCNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             cfg_ready,
  output logic             mclk,
  output logic             mclk_tick,
  output logic             bclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             lrck,
  output logic             frame_start
`ifdef ACG_FRAME_CNT_EN
  ,
  output logic [FCNT_W-1:0] frame_cnt
`endif
);

  localparam int HALF   = BCLK_DIV / 2;
  localparam int BDIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W  = (SLOT_BITS > 2) ? $clog2(SLOT_BITS) : 1;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  inc;
  logic [ACC_W-1:0]  pend_inc;
  logic              pending;
  logic [BDIV_W-1:0] bdiv;
  logic [BIT_W-1:0]  bitcnt;

  // Next-state values while running.
  logic [ACC_W:0]    sum;
  logic              wrap;
  logic [BDIV_W-1:0] bdiv_nx;
  logic              bclk_nx;
  logic              rise_nx;
  logic              fall_nx;
  logic [BIT_W-1:0]  bitcnt_nx;
  logic              lrck_nx;
  logic              fs_nx;
  logic              accept;
  logic              apply;

  assign mclk = acc[ACC_W-1];

  // NOTE: every signal gets a default at the top of the block. Without the
  // defaults, any path that skips an assignment would infer a latch.
  always_comb begin
    sum       = {1'b0, acc} + {1'b0, inc};
    wrap      = sum[ACC_W];
    bdiv_nx   = bdiv;
    rise_nx   = 1'b0;
    fall_nx   = 1'b0;
    bitcnt_nx = bitcnt;
    lrck_nx   = lrck;
    fs_nx     = 1'b0;

    if (wrap) begin
      if (bdiv == BDIV_W'(BCLK_DIV - 1)) begin
        bdiv_nx = '0;
        fall_nx = 1'b1;
      end else begin
        bdiv_nx = bdiv + 1'b1;
      end
      rise_nx = (bdiv_nx == BDIV_W'(HALF));
    end

    // LRCK advances on BCLK falling edges only, so it stays aligned to bclk_fall.
    if (fall_nx) begin
      if (bitcnt == BIT_W'(SLOT_BITS - 1)) begin
        bitcnt_nx = '0;
        lrck_nx   = ~lrck;
        fs_nx     = lrck;  // right -> left transition starts a new frame
      end else begin
        bitcnt_nx = bitcnt + 1'b1;
      end
    end

    bclk_nx = (bdiv_nx >= BDIV_W'(HALF));

    // cfg_ready is always the inverse of pending, so accept and apply are
    // mutually exclusive. A config accepted in a frame_start cycle has
    // pending still low at that edge, so it waits for the next boundary.
    accept = cfg_valid & cfg_ready;
    apply  = pending & (fs_nx | ~run);
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together from the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      inc         <= ACC_W'(DEF_INC);
      pending     <= 1'b0;
      cfg_ready   <= 1'b1;
      bdiv        <= '0;
      bitcnt      <= '0;
      mclk_tick   <= 1'b0;
      bclk        <= 1'b0;
      bclk_rise   <= 1'b0;
      bclk_fall   <= 1'b0;
      lrck        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (apply) begin
        inc       <= pend_inc;
        pending   <= 1'b0;
        cfg_ready <= 1'b1;
      end else if (accept) begin
        pending   <= 1'b1;
        cfg_ready <= 1'b0;
      end

      if (run) begin
        acc         <= sum[ACC_W-1:0];
        mclk_tick   <= wrap;
        bdiv        <= bdiv_nx;
        bclk        <= bclk_nx;
        bclk_rise   <= rise_nx;
        bclk_fall   <= fall_nx;
        bitcnt      <= bitcnt_nx;
        lrck        <= lrck_nx;
        frame_start <= fs_nx;
      end else begin
        // Stopped: clear the clock chain. inc and pending are kept.
        acc         <= '0;
        mclk_tick   <= 1'b0;
        bdiv        <= '0;
        bclk        <= 1'b0;
        bclk_rise   <= 1'b0;
        bclk_fall   <= 1'b0;
        bitcnt      <= '0;
        lrck        <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

  // NOTE: pend_inc is a data register and is intentionally not reset. It is
  // only read when pending is set, and pending is always written together
  // with pend_inc.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      pend_inc <= cfg_inc;
    end
  end

`ifdef ACG_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      frame_cnt <= '0;
    end else if (fs_nx) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_audio_clk_gen
//
// Directed testbench for audio_clk_gen, configured with ACC_W=4, BCLK_DIV=2,
// SLOT_BITS=2, DEF_INC=4 and FCNT_W=2.
//
// With increment 4 there is one mclk_tick every P=4 clocks; with increment 8,
// every P=2 clocks. Within a run segment, let u be the number of clocks since
// the segment start (acc=0, left channel). The expected outputs are then:
//   mclk_tick   = u % P == 0
//   bclk_rise   = u % 2P == P
//   bclk_fall   = u % 2P == 0
//   bclk        = u % 2P >= P
//   lrck        = u % 8P >= 4P
//   frame_start = u % 8P == 0
//   mclk        = u % P >= P/2
// -----------------------------------------------------------------------------
module tb_audio_clk_gen;

  localparam int ACC_W  = 4;
  localparam int FCNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             run;
  logic             cfg_valid;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_ready;
  logic             mclk;
  logic             mclk_tick;
  logic             bclk;
  logic             bclk_rise;
  logic             bclk_fall;
  logic             lrck;
  logic             frame_start;
`ifdef ACG_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt;
  logic [FCNT_W-1:0] exp_fcnt;
`endif

  int checks = 0;
  int errors = 0;
  int t      = 0;

  audio_clk_gen #(
    .ACC_W    (ACC_W),
    .DEF_INC  (4),
    .BCLK_DIV (2),
    .SLOT_BITS(2),
    .FCNT_W   (FCNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_inc    (cfg_inc),
    .cfg_ready  (cfg_ready),
    .mclk       (mclk),
    .mclk_tick  (mclk_tick),
    .bclk       (bclk),
    .bclk_rise  (bclk_rise),
    .bclk_fall  (bclk_fall),
    .lrck       (lrck),
    .frame_start(frame_start)
`ifdef ACG_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  // Check that every clock output and strobe is zero (stopped or in reset).
  task automatic check_zero(input string tag);
    check({tag, ".mclk"},        mclk,        0);
    check({tag, ".mclk_tick"},   mclk_tick,   0);
    check({tag, ".bclk"},        bclk,        0);
    check({tag, ".bclk_rise"},   bclk_rise,   0);
    check({tag, ".bclk_fall"},   bclk_fall,   0);
    check({tag, ".lrck"},        lrck,        0);
    check({tag, ".frame_start"}, frame_start, 0);
`ifdef ACG_FRAME_CNT_EN
    exp_fcnt = '0;
    check({tag, ".frame_cnt"},   frame_cnt,   0);
`endif
  endtask

  // Step until t == t_end. Each cycle is checked against the tick period p
  // of a run segment that started at clock 'base'.
  task automatic run_phase(input int p, input int base, input int t_end);
    int  u;
    logic fs_e;
    while (t < t_end) begin
      step();
      u    = t - base;
      fs_e = ((u % (8 * p)) == 0);
      check("mclk_tick",   mclk_tick,   (u % p) == 0);
      check("bclk_rise",   bclk_rise,   (u % (2 * p)) == p);
      check("bclk_fall",   bclk_fall,   (u % (2 * p)) == 0);
      check("bclk",        bclk,        (u % (2 * p)) >= p);
      check("lrck",        lrck,        (u % (8 * p)) >= 4 * p);
      check("frame_start", frame_start, fs_e);
      check("mclk",        mclk,        (u % p) >= p / 2);
`ifdef ACG_FRAME_CNT_EN
      if (fs_e) exp_fcnt = exp_fcnt + 1'b1;
      check("frame_cnt",   frame_cnt,   exp_fcnt);
`endif
    end
  endtask

  initial begin
    reset     = 1'b1;
    run       = 1'b0;
    cfg_valid = 1'b0;
    cfg_inc   = '0;
`ifdef ACG_FRAME_CNT_EN
    exp_fcnt  = '0;
`endif
    // Hold reset with run asserted: reset must override run.
    step();
    run = 1'b1;
    step();
    check_zero("reset");
    check("reset.cfg_ready", cfg_ready, 1);

    // Release reset at t=0 and run at the default rate (P=4).
    t     = 0;
    reset = 1'b0;
    run_phase(4, 0, 70);

    // Offer increment 8 in the middle of a frame.
    cfg_valid = 1'b1;
    cfg_inc   = 4'd8;
    run_phase(4, 0, 71);
    check("cfg_mid.ready_low", cfg_ready, 0);
    cfg_valid = 1'b0;
    run_phase(4, 0, 95);
    check("cfg_mid.still_pending", cfg_ready, 0);
    run_phase(4, 0, 96);                        // frame_start at t=96 applies it
    check("cfg_mid.ready_high", cfg_ready, 1);

    // Offer increment 4 in the frame_start cycle; expect one full frame at P=2.
    cfg_valid = 1'b1;
    cfg_inc   = 4'd4;
    run_phase(2, 96, 97);
    check("cfg_fs.ready_low", cfg_ready, 0);
    cfg_valid = 1'b0;
    run_phase(2, 96, 111);
    check("cfg_fs.still_pending", cfg_ready, 0);
    run_phase(2, 96, 112);                      // next frame_start applies 4
    check("cfg_fs.ready_high", cfg_ready, 1);
    run_phase(4, 112, 136);                     // t=136: right channel
    check("stop.was_right", lrck, 1);

    // Drop run in the middle of the right channel.
    run = 1'b0;
    step();
    check_zero("stop");

    // Restart: left channel, first tick 4 clocks later, no frame_start.
    run = 1'b1;
    run_phase(4, 137, 180);

    // Offer a config while stopped; it applies on the following clock.
    run       = 1'b0;
    cfg_valid = 1'b1;
    cfg_inc   = 4'd8;
    step();
    check_zero("stop2");
    check("stop2.ready_low", cfg_ready, 0);
    cfg_valid = 1'b0;
    step();
    check("stop2.applied", cfg_ready, 1);
    check("stop2.mclk_tick", mclk_tick, 0);
    run = 1'b1;
    run_phase(2, 182, 200);

    // Synchronous reset in the middle of a frame while running.
    reset = 1'b1;
    step();
    check_zero("reset2");
    check("reset2.cfg_ready", cfg_ready, 1);
    reset = 1'b0;
    run_phase(4, 201, 230);                     // default increment restored

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
